// File: rtl/dcache_port_arb_if.sv
// dcache_port_arb_if: load, store-buffer and data-cache signals of the port arbiter
//   master: the arbiter (drives ld_ack/ld_stall, sb_pop and the dc_* request)
//   slave : the environment (MEM stage, store buffer, cache)
interface dcache_port_arb_if #(parameter int DCW = 32);
  logic ld_req;
  logic [DCW-1:0] ld_addr;
  logic ld_ack;
  logic ld_stall;
  logic sb_valid;
  logic sb_full;
  logic [DCW-1:0] sb_addr;
  logic [DCW-1:0] sb_wdata;
  logic sb_type;
  logic sb_pop;
  logic dc_req;
  logic dc_we;
  logic [DCW-1:0] dc_addr;
  logic [DCW-1:0] dc_wdata;
  logic dc_type;
  logic dc_ready;
  modport master (
    input ld_req, ld_addr, sb_valid, sb_full, sb_addr, sb_wdata, sb_type, dc_ready,
    output ld_ack, ld_stall, sb_pop, dc_req, dc_we, dc_addr, dc_wdata, dc_type
  );
  modport slave (
    output ld_req, ld_addr, sb_valid, sb_full, sb_addr, sb_wdata, sb_type, dc_ready,
    input ld_ack, ld_stall, sb_pop, dc_req, dc_we, dc_addr, dc_wdata, dc_type
  );
endinterface

// File: rtl/dcache_port_arb.sv
// dcache_port_arb: single-port data-cache scheduler for MEM-stage loads and store-buffer drains
//   clk, reset (sync, active-high); bus: dcache_port_arb_if.master
//   `define DCARB_PERF_EN adds perf_loads/perf_drains/perf_forced event counters
module dcache_port_arb #(
  parameter int MAX_DEFER = 8,
  parameter int DCW = 32
) (
  input logic clk,
  input logic reset,
  dcache_port_arb_if.master bus
`ifdef DCARB_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_drains,
  output logic [31:0] perf_forced
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam logic [7:0] MAXD = 8'(MAX_DEFER);
  state_t state, state_n;
  logic [7:0] defer_cnt, defer_n;
  logic req_n, we_n, type_n, ack_n, pop_n, forced;
  logic [DCW-1:0] addr_n, wdata_n;
  assign bus.ld_stall = bus.ld_req & ~bus.ld_ack;
  // a full buffer or an exhausted defer budget beats a pending load
  assign forced = bus.sb_valid & (bus.sb_full | defer_cnt == MAXD);
  always_comb begin
    state_n = state;
    defer_n = defer_cnt;
    req_n = bus.dc_req;
    we_n = bus.dc_we;
    addr_n = bus.dc_addr;
    wdata_n = bus.dc_wdata;
    type_n = bus.dc_type;
    ack_n = 1'b0;
    pop_n = 1'b0;
    case (state)
      IDLE:
        if (forced || (bus.sb_valid && !bus.ld_req)) begin
          state_n = DRAIN;
          req_n = 1'b1;
          we_n = 1'b1;
          addr_n = bus.sb_addr;
          wdata_n = bus.sb_wdata;
          type_n = bus.sb_type;
          defer_n = '0;
        end else if (bus.ld_req) begin
          state_n = LOAD;
          req_n = 1'b1;
          we_n = 1'b0;
          addr_n = bus.ld_addr;
          type_n = 1'b0;
          defer_n = (bus.sb_valid && defer_cnt != MAXD) ? defer_cnt + 8'd1 : defer_cnt;
        end
      LOAD:
        if (bus.dc_ready) begin
          state_n = DONE;
          req_n = 1'b0;
          ack_n = 1'b1;
        end
      DRAIN:
        if (bus.dc_ready) begin
          state_n = DONE;
          req_n = 1'b0;
          pop_n = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      defer_cnt <= '0;
      bus.ld_ack <= 1'b0;
      bus.sb_pop <= 1'b0;
      bus.dc_req <= 1'b0;
      bus.dc_we <= 1'b0;
      bus.dc_addr <= '0;
      bus.dc_wdata <= '0;
      bus.dc_type <= 1'b0;
    end else begin
      state <= state_n;
      defer_cnt <= defer_n;
      bus.ld_ack <= ack_n;
      bus.sb_pop <= pop_n;
      bus.dc_req <= req_n;
      bus.dc_we <= we_n;
      bus.dc_addr <= addr_n;
      bus.dc_wdata <= wdata_n;
      bus.dc_type <= type_n;
    end
  end
`ifdef DCARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_loads <= '0;
      perf_drains <= '0;
      perf_forced <= '0;
    end else begin
      perf_loads <= perf_loads + {31'b0, ack_n};
      perf_drains <= perf_drains + {31'b0, pop_n};
      perf_forced <= perf_forced + {31'b0, state == IDLE && forced};
    end
  end
`endif
endmodule

// File: tb/tb_dcache_port_arb.sv
// tb_dcache_port_arb: scoreboard bench for dcache_port_arb (MAX_DEFER=2)
module tb_dcache_port_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dcache_port_arb_if #(.DCW(32)) bus ();
`ifdef DCARB_PERF_EN
  logic [31:0] perf_loads, perf_drains, perf_forced;
`endif
  dcache_port_arb #(.MAX_DEFER(2), .DCW(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DCARB_PERF_EN
    ,
    .perf_loads(perf_loads),
    .perf_drains(perf_drains),
    .perf_forced(perf_forced)
`endif
  );
  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic typ;
  } txn_t;
  txn_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int n_ack = 0;
  int n_pop = 0;
  int ready_lat = 2;
  bit auto_ready = 1'b1;
  bit man_ready = 1'b0;
  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d, input logic t);
    txn_t e;
    e.we = we;
    e.addr = a;
    e.wdata = d;
    e.typ = t;
    exp_q.push_back(e);
  endtask
  task automatic tick();
    @(posedge clk);
    #3;
  endtask
  task automatic cache_model();
    bit seen = 1'b0;
    bit pend = 1'b0;
    bit pend_we = 1'b0;
    int wc = 0;
    txn_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        checks++;
        if (bus.ld_ack !== !pend_we || bus.sb_pop !== pend_we) begin
          failures++;
          $display("FAIL resp_pulse got ack=%b pop=%b exp ack=%b pop=%b", bus.ld_ack, bus.sb_pop, !pend_we, pend_we);
        end
        if (pend_we) n_pop++;
        else n_ack++;
        pend = 1'b0;
      end else if (bus.ld_ack === 1'b1 || bus.sb_pop === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL spurious_pulse got ack=%b pop=%b exp ack=0 pop=0", bus.ld_ack, bus.sb_pop);
      end
      bus.dc_ready = auto_ready ? 1'b0 : man_ready;
      if (reset || bus.dc_req !== 1'b1) seen = 1'b0;
      else begin
        if (!seen) begin
          seen = 1'b1;
          wc = ready_lat;
        end
        if (auto_ready && wc == 0) begin
          bus.dc_ready = 1'b1;
          pend = 1'b1;
          pend_we = bus.dc_we;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow got we=%b addr=%h exp no transaction", bus.dc_we, bus.dc_addr);
          end else begin
            e = exp_q.pop_front();
            if (bus.dc_we !== e.we || bus.dc_addr !== e.addr || bus.dc_type !== e.typ || (e.we && bus.dc_wdata !== e.wdata)) begin
              failures++;
              $display("FAIL cache_txn got we=%b addr=%h wdata=%h type=%b exp we=%b addr=%h wdata=%h type=%b",
                       bus.dc_we, bus.dc_addr, bus.dc_wdata, bus.dc_type, e.we, e.addr, e.wdata, e.typ);
            end
          end
        end else if (wc > 0) wc--;
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.ld_req = 1'b0;
    bus.ld_addr = '0;
    bus.sb_valid = 1'b0;
    bus.sb_full = 1'b0;
    bus.sb_addr = '0;
    bus.sb_wdata = '0;
    bus.sb_type = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.ld_ack, bus.sb_pop, bus.dc_req, bus.dc_we, bus.dc_type, bus.ld_stall} !== 6'b0 || bus.dc_addr !== 32'h0 || bus.dc_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got ack/pop/req/we/type/stall=%b addr=%h wdata=%h exp all zero",
               {bus.ld_ack, bus.sb_pop, bus.dc_req, bus.dc_we, bus.dc_type, bus.ld_stall}, bus.dc_addr, bus.dc_wdata);
    end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_idle_load();
    int k;
    bit stall_ok = 1'b1;
    ready_lat = 2;
    push(1'b0, 32'h100, 32'h0, 1'b0);
    bus.ld_addr = 32'h100;
    bus.ld_req = 1'b1;
    tick();
    checks++;
    if (bus.dc_req !== 1'b1 || bus.dc_we !== 1'b0 || bus.dc_addr !== 32'h100) begin
      failures++;
      $display("FAIL idle_load_req got req=%b we=%b addr=%h exp 1 0 00000100", bus.dc_req, bus.dc_we, bus.dc_addr);
    end
    bus.ld_addr = 32'h999;
    for (k = 0; k < 20 && bus.ld_ack !== 1'b1; k++) begin
      if (bus.ld_stall !== 1'b1) stall_ok = 1'b0;
      tick();
    end
    checks++;
    if (k != 3) begin
      failures++;
      $display("FAIL idle_load_ack_latency got %0d exp 3", k);
    end
    checks++;
    if (!stall_ok || bus.ld_stall !== 1'b0) begin
      failures++;
      $display("FAIL idle_load_stall got held=%b at_ack=%b exp 1 0", stall_ok, bus.ld_stall);
    end
    bus.ld_req = 1'b0;
    tick();
    checks++;
    if (bus.ld_ack !== 1'b0 || bus.dc_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_load_single_ack got ack=%b req=%b exp 0 0", bus.ld_ack, bus.dc_req);
    end
  endtask
  task automatic test_idle_drain();
    int k;
    int p0 = n_pop;
    ready_lat = 1;
    push(1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
    bus.sb_addr = 32'h40;
    bus.sb_wdata = 32'hDEADBEEF;
    bus.sb_type = 1'b1;
    bus.sb_valid = 1'b1;
    tick();
    checks++;
    if (bus.dc_req !== 1'b1 || bus.dc_we !== 1'b1 || bus.dc_addr !== 32'h40 || bus.dc_wdata !== 32'hDEADBEEF || bus.dc_type !== 1'b1) begin
      failures++;
      $display("FAIL idle_drain_req got req=%b we=%b addr=%h wdata=%h type=%b exp 1 1 00000040 deadbeef 1",
               bus.dc_req, bus.dc_we, bus.dc_addr, bus.dc_wdata, bus.dc_type);
    end
    for (k = 0; k < 20 && bus.sb_pop !== 1'b1; k++) tick();
    bus.sb_valid = 1'b0;
    tick();
    checks++;
    if (k == 20 || bus.sb_pop !== 1'b0 || bus.dc_req !== 1'b0 || n_pop != p0 + 1) begin
      failures++;
      $display("FAIL idle_drain_pop got wait=%0d pop=%b req=%b pops=%0d exp wait<20 0 0 1", k, bus.sb_pop, bus.dc_req, n_pop - p0);
    end
    push(1'b0, 32'h104, 32'h0, 1'b0);
    bus.ld_addr = 32'h104;
    bus.ld_req = 1'b1;
    tick();
    checks++;
    if (bus.dc_req !== 1'b1 || bus.dc_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_done got req=%b we=%b exp 1 0", bus.dc_req, bus.dc_we);
    end
    for (k = 0; k < 20 && bus.ld_ack !== 1'b1; k++) tick();
    bus.ld_req = 1'b0;
    tick();
  endtask
  task automatic test_full_priority();
    int k;
    int a0 = n_ack;
    int p0 = n_pop;
    ready_lat = 1;
    push(1'b1, 32'h80, 32'h12345678, 1'b0);
    push(1'b0, 32'h200, 32'h0, 1'b0);
    bus.ld_addr = 32'h200;
    bus.ld_req = 1'b1;
    bus.sb_addr = 32'h80;
    bus.sb_wdata = 32'h12345678;
    bus.sb_type = 1'b0;
    bus.sb_valid = 1'b1;
    bus.sb_full = 1'b1;
    tick();
    checks++;
    if (bus.dc_req !== 1'b1 || bus.dc_we !== 1'b1 || bus.ld_stall !== 1'b1) begin
      failures++;
      $display("FAIL full_priority_first got req=%b we=%b stall=%b exp 1 1 1", bus.dc_req, bus.dc_we, bus.ld_stall);
    end
    for (k = 0; k < 20 && bus.sb_pop !== 1'b1; k++) tick();
    bus.sb_valid = 1'b0;
    bus.sb_full = 1'b0;
    for (k = 0; k < 20 && bus.ld_ack !== 1'b1; k++) tick();
    bus.ld_req = 1'b0;
    tick();
    checks++;
    if (n_ack != a0 + 1 || n_pop != p0 + 1) begin
      failures++;
      $display("FAIL full_priority_counts got acks=%0d pops=%0d exp 1 1", n_ack - a0, n_pop - p0);
    end
  endtask
  task automatic test_starvation();
    int k;
    int a0 = n_ack;
    int p0 = n_pop;
    ready_lat = 1;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 32'h500, 32'h0, 1'b0);
      push(1'b0, 32'h500, 32'h0, 1'b0);
      push(1'b1, 32'h300, 32'hA5A5A5A5, 1'b1);
    end
    bus.ld_addr = 32'h500;
    bus.ld_req = 1'b1;
    bus.sb_addr = 32'h300;
    bus.sb_wdata = 32'hA5A5A5A5;
    bus.sb_type = 1'b1;
    bus.sb_valid = 1'b1;
    for (k = 0; k < 40 && n_pop < p0 + 1; k++) tick();
    checks++;
    if (n_ack != a0 + 2 || n_pop != p0 + 1) begin
      failures++;
      $display("FAIL starve_first_drain got acks=%0d pops=%0d exp 2 1", n_ack - a0, n_pop - p0);
    end
    for (k = 0; k < 40 && n_pop < p0 + 2; k++) tick();
    bus.ld_req = 1'b0;
    bus.sb_valid = 1'b0;
    tick();
    checks++;
    if (n_ack != a0 + 4 || n_pop != p0 + 2) begin
      failures++;
      $display("FAIL starve_second_drain got acks=%0d pops=%0d exp 4 2", n_ack - a0, n_pop - p0);
    end
  endtask
  task automatic test_full_no_valid();
    bit idle_ok = 1'b1;
    bus.sb_full = 1'b1;
    bus.sb_valid = 1'b0;
    repeat (4) begin
      tick();
      if (bus.dc_req !== 1'b0) idle_ok = 1'b0;
    end
    bus.sb_full = 1'b0;
    checks++;
    if (!idle_ok) begin
      failures++;
      $display("FAIL full_without_valid got req seen=1 exp 0");
    end
  endtask
  task automatic test_ld_drop();
    int k;
    ready_lat = 1;
    push(1'b0, 32'h700, 32'h0, 1'b0);
    bus.ld_addr = 32'h700;
    bus.ld_req = 1'b1;
    tick();
    bus.ld_req = 1'b0;
    for (k = 0; k < 20 && bus.ld_ack !== 1'b1; k++) tick();
    checks++;
    if (k == 20) begin
      failures++;
      $display("FAIL ld_drop_ack got no ack exp ack");
    end
    tick();
  endtask
  task automatic test_back_to_back();
    int cyc[3];
    int n = 0;
    ready_lat = 0;
    for (int i = 0; i < 3; i++) push(1'b0, 32'h600 + 32'(4 * i), 32'h0, 1'b0);
    bus.ld_addr = 32'h600;
    bus.ld_req = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (bus.ld_ack === 1'b1) begin
        cyc[n] = c;
        n++;
        bus.ld_addr = bus.ld_addr + 32'd4;
        if (n == 3) bus.ld_req = 1'b0;
      end
    end
    bus.ld_req = 1'b0;
    checks++;
    if (n != 3 || cyc[1] - cyc[0] != 3 || cyc[2] - cyc[1] != 3) begin
      failures++;
      $display("FAIL back_to_back_period got acks=%0d gaps=%0d,%0d exp 3 3,3", n, cyc[1] - cyc[0], cyc[2] - cyc[1]);
    end
    tick();
  endtask
  task automatic test_reset_midop();
    int k;
    int p0 = n_pop;
    bit quiet = 1'b1;
    auto_ready = 1'b0;
    bus.sb_addr = 32'h44;
    bus.sb_wdata = 32'h11;
    bus.sb_valid = 1'b1;
    for (k = 0; k < 20 && bus.dc_req !== 1'b1; k++) tick();
    checks++;
    if (k == 20 || bus.dc_we !== 1'b1) begin
      failures++;
      $display("FAIL midop_drain_start got wait=%0d we=%b exp wait<20 1", k, bus.dc_we);
    end
    reset = 1'b1;
    bus.sb_valid = 1'b0;
    tick();
    checks++;
    if (bus.dc_req !== 1'b0 || bus.sb_pop !== 1'b0 || bus.dc_we !== 1'b0 || bus.dc_addr !== 32'h0 || bus.dc_wdata !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset got req=%b pop=%b we=%b addr=%h wdata=%h exp 0 0 0 0 0",
               bus.dc_req, bus.sb_pop, bus.dc_we, bus.dc_addr, bus.dc_wdata);
    end
    reset = 1'b0;
    man_ready = 1'b1;
    repeat (3) begin
      tick();
      if (bus.dc_req !== 1'b0 || bus.sb_pop !== 1'b0 || bus.ld_ack !== 1'b0) quiet = 1'b0;
    end
    man_ready = 1'b0;
    tick();
    auto_ready = 1'b1;
    checks++;
    if (!quiet || n_pop != p0) begin
      failures++;
      $display("FAIL midop_stray_ready got quiet=%b pops=%0d exp 1 0", quiet, n_pop - p0);
    end
  endtask
`ifdef DCARB_PERF_EN
  task automatic test_perf();
    int k;
    int a0;
    int p0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a0 = n_ack;
    p0 = n_pop;
    ready_lat = 1;
    for (int i = 0; i < 3; i++) push(1'b0, 32'h800, 32'h0, 1'b0);
    push(1'b1, 32'h900, 32'h1, 1'b0);
    push(1'b1, 32'h904, 32'h2, 1'b0);
    bus.ld_addr = 32'h800;
    bus.ld_req = 1'b1;
    for (k = 0; k < 40 && n_ack < a0 + 3; k++) tick();
    bus.ld_req = 1'b0;
    bus.sb_addr = 32'h900;
    bus.sb_wdata = 32'h1;
    bus.sb_valid = 1'b1;
    for (k = 0; k < 20 && n_pop < p0 + 1; k++) tick();
    bus.sb_addr = 32'h904;
    bus.sb_wdata = 32'h2;
    bus.sb_full = 1'b1;
    for (k = 0; k < 20 && n_pop < p0 + 2; k++) tick();
    bus.sb_valid = 1'b0;
    bus.sb_full = 1'b0;
    tick();
    checks++;
    if (perf_loads !== 32'd3 || perf_drains !== 32'd2 || perf_forced !== 32'd1) begin
      failures++;
      $display("FAIL perf_counters got loads=%0d drains=%0d forced=%0d exp 3 2 1", perf_loads, perf_drains, perf_forced);
    end
  endtask
`endif
  initial begin
    bus.dc_ready = 1'b0;
    fork
      cache_model();
    join_none
    test_reset();
    test_idle_load();
    test_idle_drain();
    test_full_priority();
    test_starvation();
    test_full_no_valid();
    test_ld_drop();
    test_back_to_back();
    test_reset_midop();
`ifdef DCARB_PERF_EN
    test_perf();
`endif
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
